delay_bank: RTL
===============

Name: delay_bank

Overview:
- Multi-channel temporal delay unit for the race-logic / TNN datapath. Generalises the single-channel rising/pulse delay element to NUM_CH channels.
- Adds runtime mode select, runtime pulse width, per-channel programmable delays over a valid/ready config port, and an internal gamma-cycle counter.
- Configuration changes are committed only at gamma-cycle boundaries.
- Sits between the input spike encoder and the column/neuron array.

Parameters:
- NUM_CH, 8, number of independent spike channels.
- GAMMA_CYCLE_WIDTH, 16, aclk cycles per gamma cycle (power of 2, >=4); DW = clog2(GAMMA_CYCLE_WIDTH).
- MAX_PULSE_WIDTH, 8, largest programmable pulse width; PWW = clog2(MAX_PULSE_WIDTH+1).

Ports:
- aclk  in  1  clock.
- grst  in  1  reset, asynchronous, active-high.
- in  in  NUM_CH  per-channel input spike (rising-edge or pulse encoded).
- out  out  NUM_CH  per-channel delayed spike.
- mode  in  1  0 = rising mode, 1 = pulse mode; sampled at gamma boundary.
- pulse_width  in  PWW  output pulse length in pulse mode; sampled at gamma boundary.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config write accepted when cfg_valid && cfg_ready.
- cfg_ch  in  clog2(NUM_CH)  target channel.
- cfg_delay  in  DW  new delay, range 0..GAMMA_CYCLE_WIDTH-1.
- gamma_start  out  1  high during the first cycle (gcnt==0) of each gamma cycle.

Behaviour:
- Reset (grst high): all state cleared immediately.
  - gcnt=0; per-channel cnt=0, spiked_reg=0, active delay=0, pending flag=0.
  - mode_q=0, pw_q=MAX_PULSE_WIDTH.
  - out, cfg_ready and gamma_start are forced 0 while grst is high.
- Gamma counter: gcnt increments every aclk and wraps at GAMMA_CYCLE_WIDTH-1 -> 0. gamma_last = (gcnt==GAMMA_CYCLE_WIDTH-1).
- Per channel, cnt is DW+1 bits wide and saturates at GAMMA_CYCLE_WIDTH. All compares use DW+1 bits, so delay+pw_q never overflows.
- Rising mode (mode_q=0):
  - cnt increments on each cycle in[i]=1.
  - out[i] = in[i] && (cnt >= delay[i]). This is combinational from in, zero latency.
- Pulse mode (mode_q=1):
  - spiked = in[i] | spiked_reg[i]; spiked_reg sets on in[i].
  - cnt increments while spiked.
  - out[i] = spiked && cnt >= delay[i] && cnt < delay[i]+pw_q.
  - A single-cycle input pulse at gcnt=t yields out high for gcnt t+delay .. t+delay+pw_q-1.
- Gamma boundary (clock edge that ends the gamma_last cycle), for all channels:
  - cnt and spiked_reg are cleared.
  - Pending delays are copied to active and pending flags cleared.
  - mode_q <= mode and pw_q <= pulse_width.
  - Outputs still active at the boundary are truncated: no pulse continues into the next gamma.
- Config handshake:
  - cfg_ready = !pend_flag[cfg_ch] (combinational on cfg_ch).
  - An accepted write stores cfg_delay in pending[cfg_ch] and sets the flag.
  - While the flag is set, further writes to that channel stall until the boundary; writes to other channels proceed.
  - A write accepted in the gamma_last cycle commits directly to active at the boundary edge, with the flag left 0.
  - cfg_ch >= NUM_CH: cfg_ready=1, write accepted and dropped.
- Active delay, mode and pulse width are constant within a gamma cycle. Mid-gamma config never affects current outputs.
- Edge cases:
  - pw_q=0 in pulse mode: out never asserts.
  - delay=0 in rising mode: out = in.
  - in asserted during gamma_last is counted and then cleared at the edge.
- Reset mid-operation: out drops to 0 in the same cycle grst rises. After release, gcnt restarts at 0 and gamma_start=1 on the first cycle.

Decomposition:
- Package delay_pkg holds:
  - mode enum (DLY_RISING, DLY_PULSE).
  - Width localparams DW/PWW helpers.
  - Config request struct (ch, delay).
- One sub-module delay_bank_ch: per-channel cnt/spiked_reg/active/pending logic plus the out compare, instantiated NUM_CH times by generate.
- The top holds gcnt, mode_q/pw_q, cfg decode and cfg_ready mux.

Test Plan:
- Rising mode, ch0 delay=3, in[0] high for gcnt 2..7 -> out[0] high exactly gcnt 5..7, low elsewhere; other channels silent.
- Pulse mode pw=4, ch2 delay=2, single-cycle in[2] at gcnt 4 -> out[2] high gcnt 6..9 only.
- Truncation: pulse mode delay=10, pw=8, in at gcnt 4 -> out high gcnt 14..15, low at the following gcnt 0; no residue next gamma.
- Config stall: write ch1 delay=5 at gcnt 3, second write ch1 delay=7 at gcnt 5 -> cfg_ready low for ch1 until the boundary, write to ch3 accepted meanwhile. Next gamma, ch1 uses 5; the stalled write is accepted then and applies one gamma later. Write in the gamma_last cycle -> effective next gamma.
- Mode/pw change mid-gamma: switch mode 0->1 and pw 8->2 at gcnt 6 -> current gamma unchanged; next gamma shows 2-cycle pulses.
- Async reset at gcnt 7 while out high -> out=0 in the same cycle; all delays 0 and pw_q=MAX_PULSE_WIDTH after release; gamma_start=1 on the first post-reset cycle.

Source files
------------

// File: rtl/delay_bank_pkg.sv
// Shared types and width helpers for the multi-channel race-logic delay bank.
package delay_pkg;

  localparam int unsigned DLY_NUM_CH = 8;
  localparam int unsigned DLY_GAMMA  = 16;
  localparam int unsigned DLY_MAX_PW = 8;

  // clog2 that never returns 0, so single-value fields still get one bit
  function automatic int unsigned dly_clog2(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

  localparam int unsigned DLY_DW  = dly_clog2(DLY_GAMMA);
  localparam int unsigned DLY_PWW = dly_clog2(DLY_MAX_PW + 1);
  localparam int unsigned DLY_CW  = dly_clog2(DLY_NUM_CH);

  typedef enum logic {
    DLY_RISING = 1'b0,
    DLY_PULSE  = 1'b1
  } dly_mode_e;

  typedef struct packed {
    logic [DLY_CW-1:0] ch;
    logic [DLY_DW-1:0] delay;
  } dly_cfg_req_t;

endpackage

// File: rtl/delay_bank_ch.sv
// One delay channel: spike counter, latched spike, active/pending delay and output window compare.
module delay_bank_ch
  import delay_pkg::*;
#(
  parameter int unsigned GAMMA_CYCLE_WIDTH = 16,
  parameter int unsigned DW                = 4,
  parameter int unsigned PWW               = 4
) (
  input  logic           aclk,
  input  logic           grst,
  input  logic           spike_i,
  input  logic           gamma_last_i,
  input  dly_mode_e      mode_i,
  input  logic [PWW-1:0] pw_i,
  input  logic           wr_en_i,
  input  logic [DW-1:0]  wr_delay_i,
  output logic           pend_o,
  output logic           spike_o
);

  localparam logic [DW:0] CNT_MAX = (DW+1)'(GAMMA_CYCLE_WIDTH);

  logic [DW:0]   cnt_q, cnt_d;
  logic          spiked_q, spiked_d;
  logic [DW-1:0] active_q, active_d;
  logic [DW-1:0] pending_q, pending_d;
  logic          pflag_q, pflag_d;
  logic          spiked, advance;
  logic [DW:0]   win_lo, win_hi;

  always_comb begin
    spiked  = spike_i | spiked_q;
    advance = (mode_i == DLY_PULSE) ? spiked : spike_i;
    win_lo  = {1'b0, active_q};
    win_hi  = win_lo + (DW+1)'(pw_i);

    if (mode_i == DLY_PULSE) spike_o = spiked && (cnt_q >= win_lo) && (cnt_q < win_hi);
    else                     spike_o = spike_i && (cnt_q >= win_lo);

    cnt_d     = cnt_q;
    spiked_d  = spiked_q | (spike_i && (mode_i == DLY_PULSE));
    active_d  = active_q;
    pending_d = pending_q;
    pflag_d   = pflag_q;
    if (advance && (cnt_q != CNT_MAX)) cnt_d = cnt_q + 1'b1;

    // A write landing in the last cycle bypasses pending and goes straight to active
    if (gamma_last_i) begin
      cnt_d    = '0;
      spiked_d = 1'b0;
      pflag_d  = 1'b0;
      if (wr_en_i)      active_d = wr_delay_i;
      else if (pflag_q) active_d = pending_q;
    end else if (wr_en_i) begin
      pending_d = wr_delay_i;
      pflag_d   = 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      cnt_q     <= '0;
      spiked_q  <= 1'b0;
      active_q  <= '0;
      pending_q <= '0;
      pflag_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      spiked_q  <= spiked_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      pflag_q   <= pflag_d;
    end
  end

  assign pend_o = pflag_q;

endmodule

// File: rtl/delay_bank.sv
// Multi-channel temporal delay bank; mode, pulse width and delays change only at gamma-cycle boundaries.
module delay_bank
  import delay_pkg::*;
#(
  parameter int unsigned NUM_CH            = DLY_NUM_CH,
  parameter int unsigned GAMMA_CYCLE_WIDTH = DLY_GAMMA,
  parameter int unsigned MAX_PULSE_WIDTH   = DLY_MAX_PW,
  localparam int unsigned DW  = dly_clog2(GAMMA_CYCLE_WIDTH),
  localparam int unsigned PWW = dly_clog2(MAX_PULSE_WIDTH + 1),
  localparam int unsigned CW  = dly_clog2(NUM_CH)
) (
  input  logic              aclk,
  input  logic              grst,
  input  logic [NUM_CH-1:0] in_i,
  output logic [NUM_CH-1:0] out_o,
  input  logic              mode_i,
  input  logic [PWW-1:0]    pulse_width_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [CW-1:0]     cfg_ch_i,
  input  logic [DW-1:0]     cfg_delay_i,
  output logic              gamma_start_o
);

  logic [DW-1:0]     gcnt_q, gcnt_d;
  dly_mode_e         mode_q, mode_d;
  logic [PWW-1:0]    pw_q, pw_d;
  logic              gamma_last;
  dly_cfg_req_t      cfg_req;
  logic              ch_ready, accept;
  logic [NUM_CH-1:0] pend_flag, wr_en, out_raw;

  assign cfg_req = '{ch: cfg_ch_i, delay: cfg_delay_i};

  // Out-of-range channels stay ready so their writes are silently dropped
  always_comb begin
    ch_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (int'(cfg_req.ch) == i) ch_ready = !pend_flag[i];
    end
    accept = cfg_valid_i && ch_ready;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_en[i] = accept && (int'(cfg_req.ch) == i);
    end
  end

  always_comb begin
    gamma_last = (gcnt_q == DW'(GAMMA_CYCLE_WIDTH - 1));
    gcnt_d     = gamma_last ? '0 : gcnt_q + 1'b1;
    mode_d     = gamma_last ? dly_mode_e'(mode_i) : mode_q;
    pw_d       = gamma_last ? pulse_width_i : pw_q;
  end

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      gcnt_q <= '0;
      mode_q <= DLY_RISING;
      pw_q   <= PWW'(MAX_PULSE_WIDTH);
    end else begin
      gcnt_q <= gcnt_d;
      mode_q <= mode_d;
      pw_q   <= pw_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    delay_bank_ch #(
      .GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH),
      .DW               (DW),
      .PWW              (PWW)
    ) u_ch (
      .aclk        (aclk),
      .grst        (grst),
      .spike_i     (in_i[i]),
      .gamma_last_i(gamma_last),
      .mode_i      (mode_q),
      .pw_i        (pw_q),
      .wr_en_i     (wr_en[i]),
      .wr_delay_i  (cfg_req.delay),
      .pend_o      (pend_flag[i]),
      .spike_o     (out_raw[i])
    );
  end

  assign out_o         = grst ? '0 : out_raw;
  assign cfg_ready_o   = !grst && ch_ready;
  assign gamma_start_o = !grst && (gcnt_q == '0);

endmodule
